// File: rtl/pwm_cap_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_cap_pkg
// Description : Shared types and constants for the PWM duty-cycle receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_cap_pkg;

    typedef enum logic [1:0] {
        WAIT_LOW  = 2'd0,
        WAIT_RISE = 2'd1,
        MEASURE   = 2'd2
    } cap_state_t;

    localparam int DUTY_MAX  = 100;
    localparam int DIV_STEPS = 7;
    localparam int DUTY_W    = 7;

endpackage
`default_nettype wire

// File: rtl/pwm_duty_div.sv
`default_nettype none
// ============================================================================
// Module      : pwm_duty_div
// Description : 7-step restoring divider, one quotient bit per cycle, MSB first.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_duty_div
    import pwm_cap_pkg::*;
#(
    parameter int CNT_W = 16
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CNT_W+6:0]     num,
    input  logic [CNT_W-1:0]     den,
    output logic                 busy,
    output logic                 done,
    output logic [DUTY_W-1:0]    q
);

    localparam int NUM_W = CNT_W + 7;

    logic [NUM_W-1:0]  r_rem;
    logic [CNT_W-1:0]  r_den;
    logic [2:0]        r_step;
    logic [DUTY_W-2:0] r_q;
    logic              r_busy;

    logic [NUM_W-1:0]  w_trial;
    logic              w_bit;

    // num < 128*den, so trial divisors den<<6 .. den<<0 suffice for an exact floor.
    always_comb begin
        w_trial = NUM_W'(r_den) << (3'(DIV_STEPS - 1) - r_step);
        w_bit   = (r_rem >= w_trial);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_step <= 3'd0;
            r_rem  <= '0;
            r_den  <= '0;
            r_q    <= '0;
        end else if (r_busy) begin
            if (w_bit) begin
                r_rem <= r_rem - w_trial;
            end
            r_q    <= {r_q[DUTY_W-3:0], w_bit};
            r_step <= r_step + 3'd1;
            if (r_step == 3'(DIV_STEPS - 1)) begin
                r_busy <= 1'b0;
            end
        end else if (start) begin
            r_busy <= 1'b1;
            r_step <= 3'd0;
            r_rem  <= num;
            r_den  <= den;
            r_q    <= '0;
        end
    end

    assign busy = r_busy;
    assign done = r_busy && (r_step == 3'(DIV_STEPS - 1));
    assign q    = {r_q, w_bit};

endmodule
`default_nettype wire

// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
// Module      : pwm_capture
// Description : Measures period/high time of an async PWM input, reports duty %.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_capture
    import pwm_cap_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1000
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              pwm_in,
    output logic [6:0]        duty,
    output logic              duty_valid,
    output logic [CNT_W-1:0]  period,
    output logic [CNT_W-1:0]  high_time,
    output logic              locked
);

    localparam int NUM_W = CNT_W + 7;

    logic             r_sync1;
    logic             r_s;
    logic             r_sd;
    logic [1:0]       r_arm;
    cap_state_t       r_state;
    cap_state_t       w_next;
    logic [CNT_W-1:0] r_pcnt;
    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] r_tcnt;
    logic [CNT_W-1:0] r_per_cap;
    logic [CNT_W-1:0] r_hi_cap;
    logic [6:0]       r_duty;
    logic             r_valid;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high;
    logic             r_locked;

    logic             w_rise;
    logic             w_fire;
    logic             w_load;
    logic             w_start;
    logic             w_tclr;
    logic             w_div_busy;
    logic             w_div_done;
    logic [6:0]       w_q;
    logic [NUM_W-1:0] w_num;

    // The synchroniser comes out of reset as 0 regardless of pwm_in; r_arm keeps
    // WAIT_LOW from trusting s until the real input level has propagated through.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_s     <= 1'b0;
            r_sd    <= 1'b0;
            r_arm   <= 2'b00;
        end else begin
            r_sync1 <= pwm_in;
            r_s     <= r_sync1;
            r_sd    <= r_s;
            r_arm   <= {r_arm[0], 1'b1};
        end
    end

    assign w_rise  = r_s & ~r_sd;
    assign w_fire  = (r_tcnt == CNT_W'(TIMEOUT - 1)) & ~w_rise;
    assign w_start = (r_state == MEASURE) & w_rise & ~w_div_busy;
    assign w_num   = NUM_W'(r_hcnt) * NUM_W'(DUTY_MAX);

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        case (r_state)
            WAIT_LOW: begin
                if (!r_s && r_arm[1]) begin
                    w_next = WAIT_RISE;
                end
            end
            WAIT_RISE: begin
                if (w_rise) begin
                    w_next = MEASURE;
                    w_load = 1'b1;
                end
            end
            MEASURE: begin
                if (w_rise) begin
                    w_load = 1'b1;
                end
            end
            default: w_next = WAIT_LOW;
        endcase
        if (w_fire) begin
            w_next = r_s ? WAIT_LOW : WAIT_RISE;
        end
    end

    assign w_tclr = w_rise | w_fire | ((r_state != WAIT_RISE) && (w_next == WAIT_RISE));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= WAIT_LOW;
            r_pcnt    <= '0;
            r_hcnt    <= '0;
            r_tcnt    <= '0;
            r_per_cap <= '0;
            r_hi_cap  <= '0;
        end else begin
            r_state <= w_next;
            r_tcnt  <= w_tclr ? '0 : r_tcnt + CNT_W'(1);
            if (w_load) begin
                r_pcnt <= CNT_W'(1);
                r_hcnt <= CNT_W'(1);
            end else if (r_state == MEASURE) begin
                r_pcnt <= r_pcnt + CNT_W'(1);
                r_hcnt <= r_hcnt + CNT_W'(r_s);
            end
            if (w_start) begin
                r_per_cap <= r_pcnt;
                r_hi_cap  <= r_hcnt;
            end
        end
    end

    pwm_duty_div #(
        .CNT_W (CNT_W)
    ) u_div (
        .clk   (clk),
        .reset (reset),
        .start (w_start),
        .num   (w_num),
        .den   (r_pcnt),
        .busy  (w_div_busy),
        .done  (w_div_done),
        .q     (w_q)
    );

    // A divider result takes priority over a timeout landing on the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_duty   <= '0;
            r_valid  <= 1'b0;
            r_period <= '0;
            r_high   <= '0;
            r_locked <= 1'b0;
        end else if (w_div_done) begin
            r_duty   <= w_q;
            r_valid  <= 1'b1;
            r_period <= r_per_cap;
            r_high   <= r_hi_cap;
            r_locked <= 1'b1;
        end else if (w_fire) begin
            r_duty   <= r_s ? 7'(DUTY_MAX) : 7'd0;
            r_valid  <= 1'b1;
            r_period <= '0;
            r_high   <= r_s ? CNT_W'(TIMEOUT) : '0;
            r_locked <= 1'b0;
        end else begin
            r_valid  <= 1'b0;
        end
    end

    assign duty       = r_duty;
    assign duty_valid = r_valid;
    assign period     = r_period;
    assign high_time  = r_high;
    assign locked     = r_locked;

endmodule
`default_nettype wire
